// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and helpers for the instruction fetch front end.
//   LINE_W / SLOTS / PC_W : line, slot and PC geometry
//   fetch_entry_t         : one buffered fetch {pc, line, mask}
//   mask_from_off()       : valid-slot mask for a PC entering mid-line
package imem_fetch_ctrl_pkg;

  localparam int LINE_W = 128;
  localparam int SLOTS  = 4;
  localparam int PC_W   = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [LINE_W-1:0] line;
    logic [SLOTS-1:0]  mask;
  } fetch_entry_t;

  // Slots below the entry word are not part of the fetched stream.
  function automatic logic [SLOTS-1:0] mask_from_off(input logic [1:0] off);
    logic [SLOTS-1:0] m;
    m = {SLOTS{1'b1}};
    return m << off;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fifo2.sv
// fetch_fifo2: 2-entry valid/ready FIFO with a registered head.
//   i_clk, i_resetn : clock, async active-low reset
//   i_flush         : synchronous empty, wins over push/pop
//   i_push, i_din   : write side (never pushed while full)
//   o_valid, o_head : head entry, i_pop accepts it
//   o_count         : occupancy 0..2
module fetch_fifo2
  import imem_fetch_ctrl_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_din,
  input  logic         i_pop,
  output logic         o_valid,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  fetch_entry_t ent0_q, ent1_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else if (i_flush) begin
      // Entry data is left in place; only occupancy is cleared.
      cnt_q <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= i_din;
          else               ent1_q <= i_din;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) ent0_q <= ent1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new entry lands behind whatever survives.
          if (cnt_q == 2'd2) begin
            ent0_q <= ent1_q;
            ent1_q <= i_din;
          end else begin
            ent0_q <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (cnt_q != 2'd0);
  assign o_head  = ent0_q;
  assign o_count = cnt_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: sequential line fetch with redirect handling for a
// 4-wide instruction memory (128-bit lines, fixed 1-cycle read latency).
//   i_clk, i_resetn                 : clock, async active-low reset
//   i_redirect_valid/_pc            : one-cycle redirect to a new PC
//   o_mem_valid, o_mem_raddr        : line read request (index = pc[ADDR_W+3:4])
//   i_mem_rinst                     : line read back one cycle after request
//   o_fetch_valid/_pc/_line/_mask   : head of the 2-entry buffer toward decode
//   i_fetch_ready                   : decode accepts head
// Optional: define IMEM_FETCH_PERF_EN to add saturating counters
//   o_perf_lines, o_perf_stall, o_perf_flush.
// IMEM_ADDRW sets the default line-index width.
`ifndef IMEM_ADDRW
`define IMEM_ADDRW 10
`endif

module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int          ADDR_W   = `IMEM_ADDRW,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_redirect_valid,
  input  logic [PC_W-1:0]   i_redirect_pc,
  output logic              o_mem_valid,
  output logic [ADDR_W-1:0] o_mem_raddr,
  input  logic [LINE_W-1:0] i_mem_rinst,
  output logic              o_fetch_valid,
  output logic [PC_W-1:0]   o_fetch_pc,
  output logic [LINE_W-1:0] o_fetch_line,
  output logic [SLOTS-1:0]  o_fetch_mask,
`ifdef IMEM_FETCH_PERF_EN
  output logic [31:0]       o_perf_lines,
  output logic [31:0]       o_perf_stall,
  output logic [31:0]       o_perf_flush,
`endif
  input  logic              i_fetch_ready
);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] issued_pc_q;
  logic            inflight_q;
  logic            stale_q;

  logic         pop, push, issue;
  logic [1:0]   count;
  logic [2:0]   credit;
  fetch_entry_t push_ent, head;

  assign pop = o_fetch_valid && i_fetch_ready;

  // Lines already buffered plus the one on its way back must fit in two
  // slots once this cycle's pop is accounted for. Gated by reset so the
  // request is quiet while reset is held.
  assign credit = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue  = i_resetn && !i_redirect_valid && (credit < 3'd2);

  assign o_mem_valid = issue;
  assign o_mem_raddr = fetch_pc_q[ADDR_W+3:4];

  assign push = inflight_q && !stale_q && !i_redirect_valid;

  always_comb begin
    push_ent      = '0;
    push_ent.pc   = {issued_pc_q[PC_W-1:2], 2'b00};
    push_ent.line = i_mem_rinst;
    push_ent.mask = mask_from_off(issued_pc_q[3:2]);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (i_redirect_valid) fetch_pc_d = i_redirect_pc;
    else if (issue)       fetch_pc_d = {fetch_pc_q[PC_W-1:4] + 28'd1, 4'b0000};
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) issued_pc_q <= fetch_pc_q;
      // Marks a response that belongs to the pre-redirect stream.
      stale_q <= i_redirect_valid && inflight_q;
    end
  end

  fetch_fifo2 u_fifo (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_flush  (i_redirect_valid),
    .i_push   (push),
    .i_din    (push_ent),
    .i_pop    (pop),
    .o_valid  (o_fetch_valid),
    .o_head   (head),
    .o_count  (count)
  );

  assign o_fetch_pc   = head.pc;
  assign o_fetch_line = head.line;
  assign o_fetch_mask = head.mask;

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_lines_q, perf_stall_q, perf_flush_q;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      perf_lines_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (pop && perf_lines_q != '1)                            perf_lines_q <= perf_lines_q + 32'd1;
      if (o_fetch_valid && !i_fetch_ready && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
      if (i_redirect_valid && perf_flush_q != '1)               perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign o_perf_lines = perf_lines_q;
  assign o_perf_stall = perf_stall_q;
  assign o_perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a 1-cycle registered line memory
// where line i holds {4{i}}.
module tb_imem_fetch_ctrl;

  localparam int AW = 10;

  logic          i_clk = 1'b0;
  logic          i_resetn = 1'b0;
  logic          i_redirect_valid = 1'b0;
  logic [31:0]   i_redirect_pc = '0;
  logic          o_mem_valid;
  logic [AW-1:0] o_mem_raddr;
  logic [127:0]  i_mem_rinst = '0;
  logic          o_fetch_valid;
  logic [31:0]   o_fetch_pc;
  logic [127:0]  o_fetch_line;
  logic [3:0]    o_fetch_mask;
  logic          i_fetch_ready = 1'b1;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0]   o_perf_lines, o_perf_stall, o_perf_flush;
`endif

  int nvec = 0;
  int nerr = 0;

  logic [127:0] mem [0:(1<<AW)-1];

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) i_mem_rinst <= mem[o_mem_raddr];

  imem_fetch_ctrl #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
    .i_clk            (i_clk),
    .i_resetn         (i_resetn),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_mem_valid      (o_mem_valid),
    .o_mem_raddr      (o_mem_raddr),
    .i_mem_rinst      (i_mem_rinst),
    .o_fetch_valid    (o_fetch_valid),
    .o_fetch_pc       (o_fetch_pc),
    .o_fetch_line     (o_fetch_line),
    .o_fetch_mask     (o_fetch_mask),
`ifdef IMEM_FETCH_PERF_EN
    .o_perf_lines     (o_perf_lines),
    .o_perf_stall     (o_perf_stall),
    .o_perf_flush     (o_perf_flush),
`endif
    .i_fetch_ready    (i_fetch_ready)
  );

  function automatic logic [127:0] ln(input int i);
    logic [31:0] w;
    w = i;
    return {w, w, w, w};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the middle of the next cycle; inputs change here.
  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic head(input string tag, input logic [31:0] pc, input int li, input logic [3:0] m);
    chk({tag, "_valid"}, 128'(o_fetch_valid), 128'(1'b1));
    chk({tag, "_pc"},    128'(o_fetch_pc), 128'(pc));
    chk({tag, "_line"},  o_fetch_line, ln(li));
    chk({tag, "_mask"},  128'(o_fetch_mask), 128'(m));
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = ln(i);

    // Reset state
    tick(); #1;
    chk("rst_mem_valid",   128'(o_mem_valid), 128'(0));
    chk("rst_fetch_valid", 128'(o_fetch_valid), 128'(0));
    chk("rst_pc",          128'(o_fetch_pc), 128'(0));
    chk("rst_line",        o_fetch_line, 128'(0));
    chk("rst_mask",        128'(o_fetch_mask), 128'(0));

    // Full-rate streaming after release (cycle 1 = release cycle)
    tick(); i_resetn = 1'b1; #1;
    chk("c1_mem_valid", 128'(o_mem_valid), 128'(1));
    chk("c1_raddr",     128'(o_mem_raddr), 128'(0));
    tick(); #1;
    chk("c2_raddr",     128'(o_mem_raddr), 128'(1));
    chk("c2_fvalid",    128'(o_fetch_valid), 128'(0));
    tick(); #1;
    chk("c3_raddr",     128'(o_mem_raddr), 128'(2));
    head("c3", 32'h0, 0, 4'b1111);
    tick(); #1;
    head("c4", 32'h10, 1, 4'b1111);
    tick(); #1;
    head("c5", 32'h20, 2, 4'b1111);
    chk("c5_mem_valid", 128'(o_mem_valid), 128'(1));

    // Backpressure from cycle 2
    i_resetn = 1'b0; #1; i_resetn = 1'b1;
    tick(); #1;                                   // cycle 1
    tick(); i_fetch_ready = 1'b0; #1;             // cycle 2
    tick(); #1;                                   // cycle 3
    chk("bp3_mem_valid", 128'(o_mem_valid), 128'(0));
    chk("bp3_raddr",     128'(o_mem_raddr), 128'(2));
    tick(); #1;                                   // cycle 4: two lines held
    chk("bp4_mem_valid", 128'(o_mem_valid), 128'(0));
    chk("bp4_raddr",     128'(o_mem_raddr), 128'(2));
    head("bp4", 32'h0, 0, 4'b1111);
    tick(); i_fetch_ready = 1'b1; #1;             // cycle 5
    head("bp5", 32'h0, 0, 4'b1111);
    chk("bp5_mem_valid", 128'(o_mem_valid), 128'(1));
    tick(); #1;
    head("bp6", 32'h10, 1, 4'b1111);
    tick(); #1;
    head("bp7", 32'h20, 2, 4'b1111);
    tick(); #1;
    chk("bp8_raddr", 128'(o_mem_raddr), 128'(5));  // line 5 issued here

    // Redirect while line 5 is in flight
    tick(); i_redirect_valid = 1'b1; i_redirect_pc = 32'h0000_0048; #1;
    chk("rd_mem_valid", 128'(o_mem_valid), 128'(0));
    tick(); i_redirect_valid = 1'b0; #1;
    chk("rd1_mem_valid", 128'(o_mem_valid), 128'(1));
    chk("rd1_raddr",     128'(o_mem_raddr), 128'(4));
    chk("rd1_fvalid",    128'(o_fetch_valid), 128'(0));
    tick(); #1;
    chk("rd2_fvalid",    128'(o_fetch_valid), 128'(0));
    chk("rd2_raddr",     128'(o_mem_raddr), 128'(5));
    tick(); #1;
    head("rd3", 32'h48, 4, 4'b1100);
    tick(); #1;
    head("rd4", 32'h50, 5, 4'b1111);

    // Back-to-back redirects: last one wins
    tick(); i_redirect_valid = 1'b1; i_redirect_pc = 32'h0000_0100; #1;
    tick(); i_redirect_pc = 32'h0000_0204; #1;
    chk("bb1_mem_valid", 128'(o_mem_valid), 128'(0));
    tick(); i_redirect_valid = 1'b0; #1;
    chk("bb2_raddr",     128'(o_mem_raddr), 128'(32'h20));
    chk("bb2_fvalid",    128'(o_fetch_valid), 128'(0));
    tick(); #1;
    chk("bb3_fvalid",    128'(o_fetch_valid), 128'(0));
    tick(); #1;
    head("bb4", 32'h204, 32'h20, 4'b1110);
    tick(); #1;
    head("bb5", 32'h210, 32'h21, 4'b1111);

    // PC wrap at top of address space
    tick(); i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFF0; #1;
    tick(); i_redirect_valid = 1'b0; #1;
    chk("wr1_raddr", 128'(o_mem_raddr), 128'(10'h3FF));
    tick(); #1;
    chk("wr2_raddr", 128'(o_mem_raddr), 128'(0));
    tick(); #1;
    head("wr3", 32'hFFFF_FFF0, 32'h3FF, 4'b1111);
    tick(); #1;
    head("wr4", 32'h0, 0, 4'b1111);

    // Reset while the buffer is full
    tick(); i_fetch_ready = 1'b0; #1;
    tick(); tick(); tick(); #1;
    chk("mr_full_fvalid", 128'(o_fetch_valid), 128'(1));
    chk("mr_full_mvalid", 128'(o_mem_valid), 128'(0));
    i_resetn = 1'b0; #1;
    chk("mr_mem_valid",   128'(o_mem_valid), 128'(0));
    chk("mr_fetch_valid", 128'(o_fetch_valid), 128'(0));
    chk("mr_pc",          128'(o_fetch_pc), 128'(0));
    chk("mr_line",        o_fetch_line, 128'(0));
    chk("mr_mask",        128'(o_fetch_mask), 128'(0));
    tick(); tick(); i_resetn = 1'b1; i_fetch_ready = 1'b1; #1;
    chk("mr1_mem_valid", 128'(o_mem_valid), 128'(1));
    chk("mr1_raddr",     128'(o_mem_raddr), 128'(0));
    tick(); #1;
    chk("mr2_fvalid",    128'(o_fetch_valid), 128'(0));
    tick(); #1;
    head("mr3", 32'h0, 0, 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
